// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush sequencer for a 5-stage pipeline (load-use, branch
//            flush, data-memory wait) with perf counters and timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [4:0]           Rs1D,
    input  logic [4:0]           Rs2D,
    input  logic [4:0]           RdE,
    input  logic                 ResultSrcE0,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 MemErr,
    output logic [CNT_WIDTH-1:0] StallCnt,
    output logic [CNT_WIDTH-1:0] FlushCnt
);

    localparam int LU_W = (LOAD_USE_CYCLES > 1) ? $clog2(LOAD_USE_CYCLES + 1) : 1;
    localparam int WT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [LU_W-1:0] LU_RELOAD = LU_W'(LOAD_USE_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LIMIT  = WT_W'(TIMEOUT_CYCLES);
    localparam bit              MULTI_LU  = (LOAD_USE_CYCLES > 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t            state, state_nxt, eff_state;
    logic [LU_W-1:0]   lu_cnt, lu_cnt_nxt;
    logic [WT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic              lu_hazard, mem_wait, err_set, flush_inc;

    assign lu_hazard = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
    assign mem_wait  = MemReqM & ~MemReadyM;

    always_comb begin
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        StallM       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushW       = 1'b0;
        state_nxt    = state;
        eff_state    = state;
        lu_cnt_nxt   = lu_cnt;
        wait_cnt_nxt = '0;
        err_set      = 1'b0;
        flush_inc    = 1'b0;

        if (mem_wait) begin
            StallF       = 1'b1;
            StallD       = 1'b1;
            StallE       = 1'b1;
            StallM       = 1'b1;
            FlushW       = 1'b1;
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = (wait_cnt != WT_LIMIT) ? wait_cnt + 1'b1 : wait_cnt;
            err_set      = (wait_cnt_nxt == WT_LIMIT);
        end else begin
            // A completed wait resumes whatever load-use sequence it interrupted.
            if (state == MEM_WAIT)
                eff_state = (lu_cnt != '0) ? LU_STALL : RUN;

            if (PCSrcE) begin
                FlushD     = 1'b1;
                FlushE     = 1'b1;
                lu_cnt_nxt = '0;
                state_nxt  = RUN;
                flush_inc  = 1'b1;
            end else if (eff_state == LU_STALL) begin
                StallF     = 1'b1;
                StallD     = 1'b1;
                FlushE     = 1'b1;
                lu_cnt_nxt = lu_cnt - 1'b1;
                state_nxt  = (lu_cnt == LU_W'(1)) ? RUN : LU_STALL;
            end else if (lu_hazard) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                if (MULTI_LU) begin
                    lu_cnt_nxt = LU_RELOAD;
                    state_nxt  = LU_STALL;
                end else begin
                    state_nxt  = RUN;
                end
            end else begin
                state_nxt = RUN;
            end
        end

        // While reset is held, bubble every register and stall nothing.
        if (!rst_n) begin
            StallF = 1'b0;
            StallD = 1'b0;
            StallE = 1'b0;
            StallM = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            lu_cnt   <= '0;
            wait_cnt <= '0;
            MemErr   <= 1'b0;
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            state    <= state_nxt;
            lu_cnt   <= lu_cnt_nxt;
            wait_cnt <= wait_cnt_nxt;
            MemErr   <= MemErr | err_set;
            if (StallF && (StallCnt != '1))
                StallCnt <= StallCnt + 1'b1;
            if (flush_inc && (FlushCnt != '1))
                FlushCnt <= FlushCnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed self-checking bench; two instances (1-cycle load-use /
//            64 timeout, and 3-cycle load-use / 4 timeout / 4-bit counters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] MW   = 7'b1111001;
    localparam logic [6:0] RST  = 7'b0000111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1D, Rs2D, RdE;
    logic       ResultSrcE0, PCSrcE, MemReqM, MemReadyM;

    logic        a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw, a_err;
    logic [15:0] a_sc, a_fc;
    logic        b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_err;
    logic [3:0]  b_sc, b_fc;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.LOAD_USE_CYCLES(1), .TIMEOUT_CYCLES(64), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(a_sf), .StallD(a_sd), .StallE(a_se), .StallM(a_sm),
        .FlushD(a_fd), .FlushE(a_fe), .FlushW(a_fw), .MemErr(a_err),
        .StallCnt(a_sc), .FlushCnt(a_fc)
    );

    pipeline_ctrl #(.LOAD_USE_CYCLES(3), .TIMEOUT_CYCLES(4), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm),
        .FlushD(b_fd), .FlushE(b_fe), .FlushW(b_fw), .MemErr(b_err),
        .StallCnt(b_sc), .FlushCnt(b_fc)
    );

    wire [6:0] a_out = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fw};
    wire [6:0] b_out = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic ld, input logic pc, input logic req, input logic rdy);
        Rs1D = rs1; Rs2D = rs2; RdE = rd;
        ResultSrcE0 = ld; PCSrcE = pc; MemReqM = req; MemReadyM = rdy;
        #1;
    endtask

    task automatic idle();
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic [6:0] ea, input logic [6:0] eb);
        check({tag, "_a"}, 32'(a_out), 32'(ea));
        check({tag, "_b"}, 32'(b_out), 32'(eb));
    endtask

    task automatic cnts(input string tag, input int sa, input int sb, input int fa, input int fb);
        check({tag, "_sc_a"}, 32'(a_sc), 32'(sa));
        check({tag, "_sc_b"}, 32'(b_sc), 32'(sb));
        check({tag, "_fc_a"}, 32'(a_fc), 32'(fa));
        check({tag, "_fc_b"}, 32'(b_fc), 32'(fb));
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        outs("reset", RST, RST);
        cnts("reset", 0, 0, 0, 0);
        check("reset_err_a", 32'(a_err), 0);
        check("reset_err_b", 32'(b_err), 0);
        #10 rst_n = 1'b1;
        tick();

        idle();
        outs("run_idle", NONE, NONE);
        tick();

        // Load-use hazard on Rs1D
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        outs("lu_hit", LU, LU);
        tick();
        idle();
        outs("lu_2", NONE, LU);
        check("lu1_sc_a", 32'(a_sc), 1);
        tick();
        outs("lu_3", NONE, LU);
        tick();
        outs("lu_done", NONE, NONE);
        cnts("lu", 1, 3, 0, 0);

        drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        outs("rd_zero", NONE, NONE);
        tick();

        // Branch in the same cycle as a load-use hazard on Rs2D
        drive(5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        outs("br_lu", BR, BR);
        tick();
        idle();
        outs("br_after", NONE, NONE);
        cnts("br", 1, 3, 1, 1);
        tick();

        // Five wait cycles; PCSrcE asserted mid-wait must be ignored
        for (int i = 0; i < 5; i++) begin
            drive(5'd1, 5'd2, 5'd3, 1'b0, (i == 2), 1'b1, 1'b0);
            outs($sformatf("wait%0d", i), MW, MW);
            check($sformatf("wait%0d_err_b", i), 32'(b_err), (i >= 4) ? 1 : 0);
            tick();
        end
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        outs("wait_ready", NONE, NONE);
        cnts("wait", 6, 8, 1, 1);
        check("wait_err_a", 32'(a_err), 0);
        check("wait_err_b", 32'(b_err), 1);
        tick();
        idle();
        check("err_sticky_b", 32'(b_err), 1);
        tick();

        // Wait arriving while the 3-cycle instance is in LU_STALL with lu_cnt=2
        drive(5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        outs("lu_w_hit", LU, LU);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
            outs($sformatf("lu_w%0d", i), MW, MW);
            tick();
        end
        drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
        outs("lu_w_res1", NONE, LU);
        tick();
        idle();
        outs("lu_w_res2", NONE, LU);
        tick();
        outs("lu_w_done", NONE, NONE);
        cnts("lu_w", 10, 14, 1, 1);

        // Saturation of the 4-bit counters
        drive(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        outs("sat_done", NONE, NONE);
        check("sat_sc_a", 32'(a_sc), 11);
        check("sat_sc_b", 32'(b_sc), 15);
        for (int i = 0; i < 16; i++) begin
            drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("sat_fc_a", 32'(a_fc), 17);
        check("sat_fc_b", 32'(b_fc), 15);

        // Async reset in the middle of a wait
        for (int i = 0; i < 2; i++) begin
            drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        rst_n = 1'b0;
        #1;
        outs("mid_rst", RST, RST);
        cnts("mid_rst", 0, 0, 0, 0);
        check("mid_rst_err_a", 32'(a_err), 0);
        check("mid_rst_err_b", 32'(b_err), 0);
        idle();
        #2 rst_n = 1'b1;
        tick();
        outs("post_rst", NONE, NONE);

        // Fresh timeout count after reset: error appears only after the 4th wait
        for (int i = 0; i < 4; i++) begin
            drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
            check($sformatf("rewait%0d_err_b", i), 32'(b_err), 0);
            tick();
        end
        check("rewait_err_b", 32'(b_err), 1);
        check("rewait_err_a", 32'(a_err), 0);
        check("rewait_sc_a", 32'(a_sc), 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
